bram_ctrl: RTL and testbench
============================

# bram_ctrl

Frame-write controller for the receiver BRAM. On a start request, `en` high with the host-ready word on `dout` non-zero, it writes one frame of `N_WORDS` 32-bit words into the BRAM port: an incrementing word index at byte addresses 0, 4, 8, …. It then waits for `en` to be released before another frame can start. It sits between the receive datapath enable and a 32-bit BRAM port, and emits `rst_count` to restart the external sample counter at frame start.

## Interface
- `N_WORDS`, default 16: words written per frame; legal range 1..65535.
- `ADDR_STEP`, default 4: byte increment between consecutive addresses.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `en`  in  1: acquisition enable / start request (level).
- `dout`  in  32: host-ready word read from BRAM; non-zero means the buffer is free.
- `din`  out  32: write data; equals the word index of the current write.
- `valid`  out  1: write strobe; one word written per cycle while high.
- `addr`  out  32: BRAM byte address; equals `ADDR_STEP` × word index.
- `rst_count`  out  1: one-cycle pulse restarting the external sample counter.

## Operation
- All outputs are registered.
- On reset: state IDLE; `valid`, `rst_count`, `din` and `addr` are all 0.
- The word index is 16 bits internally and is zero-extended onto `din`.
- **IDLE**
  - Outputs are 0.
  - If `en`=1 and `dout`≠0 at an edge: go to WRITE, `rst_count`=1, `valid`=1, `addr`=0, `din`=0.
  - If `en`=1 and `dout`=0: stay in IDLE. The start waits until `dout` becomes non-zero while `en` is still high.
- **WRITE**
  - `rst_count` returns to 0 after its single cycle.
  - While `en`=1 and the index is below `N_WORDS`-1: index increments, `addr` += `ADDR_STEP`, `din` = index, `valid` stays 1.
  - At an edge where the index equals `N_WORDS`-1 and `en`=1: go to DONE; `valid`=0, `addr`=0, `din`=0.
  - `en`=0 sampled at any WRITE edge aborts the frame: go to IDLE; `valid`=0, `addr`=0, `din`=0. The word already presented is the last one written.
  - `dout` is ignored in WRITE.
- **DONE**
  - Outputs are 0.
  - Stays in DONE while `en`=1, so exactly one frame is written per `en` assertion.
  - `en`=0 returns the block to IDLE.
- `rst` has priority over all transitions. Reset mid-frame drops `valid` and `addr` to 0 at that edge, with no further writes.

## Timing
- Start latency: `valid` and `rst_count` rise one cycle after the edge that samples `en`=1 and `dout`≠0.
- Frame length: exactly `N_WORDS` consecutive `valid` cycles, with no gaps. The addresses cover 0 .. `ADDR_STEP`×(`N_WORDS`-1).
- `rst_count` is high only during the first write cycle (address 0).
- Abort latency: `valid` falls at the first edge that samples `en`=0.
- Restart: at least one cycle in IDLE with `en`=0 is required between frames. A new start is possible on the first edge after IDLE is re-entered, if `en`=1 and `dout`≠0.
- Addresses never wrap within a frame, and `addr` never exceeds `ADDR_STEP`×(`N_WORDS`-1).

## Test plan
- Reset: assert `rst` for 2 cycles with `en`=1 and `dout`=1. Required: all outputs 0 throughout, and the start happens only on the edge after `rst` is released.
- Full frame (`N_WORDS`=16): raise `en` with `dout`=1 and hold it. Required:
  - 16 consecutive `valid` cycles with `addr`=0,4,…,60 and `din`=0..15.
  - `rst_count` high in the first of those cycles only.
  - Then `valid`=0 while `en` stays high.
- Ready gating: `en`=1 with `dout`=0 for 10 cycles, then `dout`=1. Required: no `valid` during the 10 cycles; the frame starts 1 cycle after `dout`=1 is sampled.
- Abort: `en`=1, `dout`=1, drop `en` after 12 cycles, and set `dout`=0 after 10 cycles. Required:
  - Writes stop at the edge that samples `en`=0, giving fewer than 16 words.
  - `addr` returns to 0.
  - The `dout` change has no effect on the writes already in progress.
- Re-arm: after DONE, drop `en` for 1 cycle and raise it again with `dout`=1. Required: a second full frame starting at `addr`=0, with a fresh `rst_count` pulse.
- Mid-frame reset: assert `rst` at write index 5. Required: `valid`=0 and `addr`=0 at the next edge, and the block restarts from IDLE.

Source files
------------

// File: rtl/bram_if.sv
// Write-side bus between the frame controller and the BRAM port, plus the
// enable/ready inputs that gate a frame.
interface bram_if;
  logic        en;
  logic [31:0] dout;
  logic [31:0] din;
  logic        valid;
  logic [31:0] addr;
  logic        rst_count;

  modport master (input en, dout, output din, valid, addr, rst_count);
  modport slave  (output en, dout, input din, valid, addr, rst_count);
endinterface

// File: rtl/bram_ctrl.sv
// Frame-write controller: on en with a non-zero ready word, writes N_WORDS
// incrementing words to BRAM, then waits for en to drop before re-arming.
module bram_ctrl #(
  parameter int N_WORDS   = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic   clk,
  input  logic   rst,
  bram_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [15:0] LAST = 16'(N_WORDS - 1);
  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t      state, state_nxt;
  logic [15:0] idx, idx_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic        valid_q, valid_nxt;
  logic        rc_q, rc_nxt;
  logic        start;

  assign start = bus.en && (bus.dout != 32'h0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (!bus.en) state_nxt = IDLE;
               else if (idx == LAST) state_nxt = DONE;
      DONE:    if (!bus.en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle output values; anything not explicitly writing returns to 0.
  always_comb begin
    idx_nxt   = '0;
    addr_nxt  = '0;
    valid_nxt = 1'b0;
    rc_nxt    = 1'b0;
    case (state)
      IDLE: if (start) begin
        valid_nxt = 1'b1;
        rc_nxt    = 1'b1;
      end
      WRITE: if (bus.en && idx != LAST) begin
        valid_nxt = 1'b1;
        idx_nxt   = idx + 16'd1;
        addr_nxt  = addr_q + STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      rc_q    <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      addr_q  <= addr_nxt;
      valid_q <= valid_nxt;
      rc_q    <= rc_nxt;
    end
  end

  assign bus.din       = {16'h0, idx};
  assign bus.addr      = addr_q;
  assign bus.valid     = valid_q;
  assign bus.rst_count = rc_q;
endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl: expected writes queued at stimulus time,
// checked by a negedge monitor as the controller emits them.
module tb_bram_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        rc;
  } exp_t;

  exp_t sb[$];

  bram_if bus ();

  bram_ctrl #(.N_WORDS(16), .ADDR_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.addr = 32'(i * 4);
      e.din  = 32'(i);
      e.rc   = (i == 0);
      sb.push_back(e);
    end
  endtask

  // Every write strobe must match the next queued word; idle cycles must be all zero.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.addr, e.addr);
        chk("wr_din", bus.din, e.din);
        chk("wr_rst_count", 32'(bus.rst_count), 32'(e.rc));
      end
    end else begin
      chk("idle_valid", 32'(bus.valid), 32'd0);
      chk("idle_addr", bus.addr, 32'd0);
      chk("idle_din", bus.din, 32'd0);
      chk("idle_rst_count", 32'(bus.rst_count), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.dout = 32'd1;

    // reset held with a pending start
    step(2);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    rst = 1'b0;
    push_frame(16);
    @(negedge clk);
    chk("no_start_before_release", 32'(bus.valid), 32'd0);
    step(1);
    chk("start_valid", 32'(bus.valid), 32'd1);
    chk("start_rst_count", 32'(bus.rst_count), 32'd1);
    step(16);
    chk("done_valid_low", 32'(bus.valid), 32'd0);
    step(3);
    chk("done_hold_low", 32'(bus.valid), 32'd0);
    chk("frame1_drained", sb.size(), 32'd0);

    // re-arm after one en-low cycle
    bus.en = 1'b0;
    step(1);
    bus.en = 1'b1;
    push_frame(16);
    step(1);
    chk("rearm_valid", 32'(bus.valid), 32'd1);
    chk("rearm_rst_count", 32'(bus.rst_count), 32'd1);
    step(16);
    chk("rearm_done", 32'(bus.valid), 32'd0);
    chk("rearm_drained", sb.size(), 32'd0);

    // ready gating
    bus.en = 1'b0;
    step(1);
    bus.en = 1'b1;
    bus.dout = 32'd0;
    step(10);
    chk("gate_no_valid", 32'(bus.valid), 32'd0);
    bus.dout = 32'd1;
    push_frame(16);
    step(1);
    chk("gate_start", 32'(bus.valid), 32'd1);
    step(16);
    chk("gate_done", 32'(bus.valid), 32'd0);
    chk("gate_drained", sb.size(), 32'd0);

    // abort: 12 words, dout drop mid-frame is ignored
    bus.en = 1'b0;
    step(1);
    bus.en = 1'b1;
    push_frame(12);
    step(10);
    bus.dout = 32'd0;
    step(2);
    chk("abort_last_din", bus.din, 32'd11);
    bus.en = 1'b0;
    step(1);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    chk("abort_addr", bus.addr, 32'd0);
    chk("abort_drained", sb.size(), 32'd0);
    bus.dout = 32'd1;
    step(2);
    chk("abort_stays_idle", 32'(bus.valid), 32'd0);

    // reset at write index 5
    bus.en = 1'b1;
    push_frame(6);
    step(6);
    chk("mid_idx5", bus.din, 32'd5);
    rst = 1'b1;
    step(1);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_addr", bus.addr, 32'd0);
    chk("mid_rst_drained", sb.size(), 32'd0);
    rst = 1'b0;
    push_frame(16);
    step(1);
    chk("post_rst_start", 32'(bus.valid), 32'd1);
    chk("post_rst_rc", 32'(bus.rst_count), 32'd1);
    step(16);
    chk("post_rst_done", 32'(bus.valid), 32'd0);
    chk("post_rst_drained", sb.size(), 32'd0);

    bus.en = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
